// File: rtl/serial_io_ctrl_pkg.sv
// Shared addresses, FIFO depth and FSM encodings for the memory-mapped serial I/O controller.
package serial_io_ctrl_pkg;

   localparam logic [31:0] DEF_DATA_ADDR   = 32'hFFFF_0000;
   localparam logic [31:0] DEF_STATUS_ADDR = 32'hFFFF_0004;
   localparam int          DEF_RX_DEPTH    = 4;

   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_TAKE = 2'd1,
      RX_GAP  = 2'd2
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_WRITE = 2'd1,
      TX_HOLD  = 2'd2
   } tx_state_t;

   function automatic logic [31:0] status_word(input logic tx_ready, input logic rx_avail);
      return {30'b0, tx_ready, rx_avail};
   endfunction

endpackage

// File: rtl/serial_io_ctrl_rx_fifo.sv
// Small synchronous FIFO that buffers received serial bytes until the processor loads them.
module rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             push_ok;
   logic             pop_ok;

   // The extra pointer bit tells a full FIFO apart from an empty one.
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rptr[AW-1:0]];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/serial_io_ctrl.sv
// Memory-mapped serial port controller: decodes data/status addresses, prefetches RX bytes
// into a FIFO, sequences TX writes and stalls the datapath until an access can complete.
module serial_io_ctrl
   import serial_io_ctrl_pkg::*;
#(
   parameter logic [31:0] DATA_ADDR   = DEF_DATA_ADDR,
   parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
   parameter int          RX_DEPTH    = DEF_RX_DEPTH
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_hit,
   output logic        stall,
   input  logic [7:0]  serial_in,
   input  logic        serial_valid_in,
   input  logic        serial_ready_in,
   output logic [7:0]  serial_out,
   output logic        serial_rden_out,
   output logic        serial_wren_out
);

   rx_state_t  rx_state;
   tx_state_t  tx_state;
   logic       hit_data;
   logic       hit_status;
   logic       store_req;
   logic       load_data;
   logic       load_status;
   logic       tx_ready;
   logic       push;
   logic       pop;
   logic       fifo_empty;
   logic       fifo_full;
   logic [7:0] fifo_dout;
   logic       wdata_unused;

   assign wdata_unused = ^mem_wdata[31:8];

   // A simultaneous load and store is treated as a store; the load side is dropped.
   assign hit_data    = (mem_addr == DATA_ADDR);
   assign hit_status  = (mem_addr == STATUS_ADDR);
   assign mem_hit     = hit_data || hit_status;
   assign store_req   = mem_wr && hit_data;
   assign load_data   = mem_rd && !mem_wr && hit_data;
   assign load_status = mem_rd && !mem_wr && hit_status;
   assign tx_ready    = serial_ready_in && (tx_state == TX_IDLE);
   assign push        = (rx_state == RX_IDLE) && serial_valid_in && !fifo_full;
   assign pop         = load_data && !fifo_empty;

   rx_fifo #(
      .DEPTH(RX_DEPTH),
      .WIDTH(8)
   ) u_rx_fifo (
      .clock(clock),
      .reset(reset),
      .push (push),
      .pop  (pop),
      .din  (serial_in),
      .dout (fifo_dout),
      .empty(fifo_empty),
      .full (fifo_full)
   );

   always_comb begin
      mem_rdata = 32'h0;
      stall     = 1'b0;
      if (store_req) begin
         stall = !tx_ready;
      end else if (load_data) begin
         stall = fifo_empty;
         if (!fifo_empty) mem_rdata = {24'b0, fifo_dout};
      end else if (load_status) begin
         mem_rdata = status_word(tx_ready, !fifo_empty);
      end
   end

   // RX sequencing leaves a gap cycle so the sender can drop valid after the rden pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_state        <= RX_IDLE;
         serial_rden_out <= 1'b0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               if (push) begin
                  rx_state        <= RX_TAKE;
                  serial_rden_out <= 1'b1;
               end
            end
            RX_TAKE: begin
               rx_state        <= RX_GAP;
               serial_rden_out <= 1'b0;
            end
            RX_GAP:  rx_state <= RX_IDLE;
            default: begin
               rx_state        <= RX_IDLE;
               serial_rden_out <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_state        <= TX_IDLE;
         serial_out      <= 8'h0;
         serial_wren_out <= 1'b0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (store_req && serial_ready_in) begin
                  tx_state        <= TX_WRITE;
                  serial_out      <= mem_wdata[7:0];
                  serial_wren_out <= 1'b1;
               end
            end
            TX_WRITE: begin
               tx_state        <= TX_HOLD;
               serial_wren_out <= 1'b0;
            end
            TX_HOLD: tx_state <= TX_IDLE;
            default: begin
               tx_state        <= TX_IDLE;
               serial_wren_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_io_ctrl.sv
// Directed self-checking bench for serial_io_ctrl: reset, RX prefetch, FIFO full, TX sequencing.
module tb_serial_io_ctrl;

   localparam logic [31:0] DATA_A   = 32'hFFFF_0000;
   localparam logic [31:0] STATUS_A = 32'hFFFF_0004;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_hit;
   logic        stall;
   logic [7:0]  serial_in;
   logic        serial_valid_in;
   logic        serial_ready_in;
   logic [7:0]  serial_out;
   logic        serial_rden_out;
   logic        serial_wren_out;

   int checks = 0;
   int errors = 0;

   serial_io_ctrl dut (
      .clock          (clock),
      .reset          (reset),
      .mem_addr       (mem_addr),
      .mem_rd         (mem_rd),
      .mem_wr         (mem_wr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_hit        (mem_hit),
      .stall          (stall),
      .serial_in      (serial_in),
      .serial_valid_in(serial_valid_in),
      .serial_ready_in(serial_ready_in),
      .serial_out     (serial_out),
      .serial_rden_out(serial_rden_out),
      .serial_wren_out(serial_wren_out)
   );

   always #5 clock = ~clock;

   task automatic bus_idle();
      mem_rd          = 1'b0;
      mem_wr          = 1'b0;
      mem_addr        = 32'h0;
      mem_wdata       = 32'h0;
      serial_in       = 8'h0;
      serial_valid_in = 1'b0;
      serial_ready_in = 1'b0;
   endtask

   task automatic wait_rden(input int limit, output logic got);
      got = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(posedge clock);
         #1;
         if (serial_rden_out) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      mem_addr = DATA_A; mem_wr = 1'b1; mem_wdata = 32'h0000_00AB; serial_ready_in = 1'b1;
      serial_valid_in = 1'b1; serial_in = 8'h77;
      @(negedge clock);
      mem_wr = 1'b0; serial_valid_in = 1'b0;
      #1;
      checks++; if (serial_wren_out !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_wren: got %0b expected 1", serial_wren_out); end
      checks++; if (serial_rden_out !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_rden: got %0b expected 1", serial_rden_out); end
      #2 reset = 1'b0;
      #1;
      checks++; if (serial_wren_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_wren: got %0b expected 0", serial_wren_out); end
      checks++; if (serial_rden_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_rden: got %0b expected 0", serial_rden_out); end
      checks++; if (serial_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_serial_out: got %h expected 00", serial_out); end
      mem_rd = 1'b1; mem_addr = STATUS_A; serial_ready_in = 1'b0;
      #1;
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_status_nr: got %h expected 00000000", mem_rdata); end
      checks++; if (mem_hit !== 1'b1) begin errors++; $display("[TB] FAIL reset_status_hit: got %0b expected 1", mem_hit); end
      serial_ready_in = 1'b1;
      #1;
      checks++; if (mem_rdata !== 32'h2) begin errors++; $display("[TB] FAIL reset_status_rdy: got %h expected 00000002", mem_rdata); end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      #1;
      checks++; if (mem_rdata !== 32'h2) begin errors++; $display("[TB] FAIL post_reset_status: got %h expected 00000002", mem_rdata); end
      bus_idle();
      repeat (2) @(negedge clock);
   endtask

   task automatic test_rx_single();
      int cnt = 0;
      @(negedge clock);
      serial_valid_in = 1'b1; serial_in = 8'h41;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock);
         #1;
         if (serial_rden_out) cnt++;
         if (i == 1) serial_valid_in = 1'b0;
      end
      checks++; if (cnt !== 1) begin errors++; $display("[TB] FAIL rx_single_pulses: got %0d expected 1", cnt); end
      @(negedge clock);
      mem_rd = 1'b1; mem_addr = DATA_A;
      #1;
      checks++; if (mem_rdata !== 32'h0000_0041) begin errors++; $display("[TB] FAIL rx_single_data: got %h expected 00000041", mem_rdata); end
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rx_single_stall: got %0b expected 0", stall); end
      @(negedge clock);
      mem_addr = STATUS_A;
      #1;
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rx_single_drained: got %h expected 00000000", mem_rdata); end
      bus_idle();
      repeat (2) @(negedge clock);
   endtask

   task automatic test_rx_stall();
      int stalled = 0;
      @(negedge clock);
      mem_rd = 1'b1; mem_addr = DATA_A;
      #1;
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rx_stall_rdata: got %h expected 00000000", mem_rdata); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         #1;
         if (stall) stalled++;
      end
      checks++; if (stalled !== 4) begin errors++; $display("[TB] FAIL rx_stall_cycles: got %0d expected 4", stalled); end
      serial_valid_in = 1'b1; serial_in = 8'h5A;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL rx_stall_before_push: got %0b expected 1", stall); end
      @(negedge clock);
      serial_valid_in = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rx_stall_release: got %0b expected 0", stall); end
      checks++; if (mem_rdata !== 32'h0000_005A) begin errors++; $display("[TB] FAIL rx_stall_data: got %h expected 0000005a", mem_rdata); end
      @(negedge clock);
      bus_idle();
      repeat (3) @(negedge clock);
   endtask

   task automatic test_rx_full();
      int   pulses = 0;
      logic got;
      for (int b = 1; b <= 4; b++) begin
         @(negedge clock);
         serial_valid_in = 1'b1; serial_in = b[7:0];
         wait_rden(8, got);
         if (got) pulses++;
         @(negedge clock);
         serial_valid_in = 1'b0;
      end
      checks++; if (pulses !== 4) begin errors++; $display("[TB] FAIL rx_full_pulses: got %0d expected 4", pulses); end
      @(negedge clock);
      serial_valid_in = 1'b1; serial_in = 8'h05;
      wait_rden(6, got);
      checks++; if (got !== 1'b0) begin errors++; $display("[TB] FAIL rx_full_ignored: got %0b expected 0", got); end
      @(negedge clock);
      mem_rd = 1'b1; mem_addr = DATA_A;
      #1;
      checks++; if (mem_rdata !== 32'h01) begin errors++; $display("[TB] FAIL rx_full_pop1: got %h expected 00000001", mem_rdata); end
      @(negedge clock);
      mem_rd = 1'b0;
      wait_rden(6, got);
      checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL rx_full_fifth_push: got %0b expected 1", got); end
      @(negedge clock);
      serial_valid_in = 1'b0;
      for (int k = 2; k <= 5; k++) begin
         @(negedge clock);
         mem_rd = 1'b1; mem_addr = DATA_A;
         #1;
         checks++; if (mem_rdata !== k) begin errors++; $display("[TB] FAIL rx_full_order: got %h expected %h", mem_rdata, k); end
      end
      @(negedge clock);
      mem_addr = STATUS_A;
      #1;
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rx_full_drained: got %h expected 00000000", mem_rdata); end
      bus_idle();
      repeat (3) @(negedge clock);
   endtask

   task automatic test_back_to_back();
      int stalled = 0;
      @(negedge clock);
      mem_wr = 1'b1; mem_addr = DATA_A; mem_wdata = 32'h1234_56C3; serial_ready_in = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL tx_first_stall: got %0b expected 0", stall); end
      @(negedge clock);
      mem_wdata = 32'h0000_00A5;
      #1;
      checks++; if (serial_out !== 8'hC3) begin errors++; $display("[TB] FAIL tx_first_out: got %h expected c3", serial_out); end
      checks++; if (serial_wren_out !== 1'b1) begin errors++; $display("[TB] FAIL tx_first_wren: got %0b expected 1", serial_wren_out); end
      if (stall) stalled++;
      @(negedge clock);
      #1;
      checks++; if (serial_wren_out !== 1'b0) begin errors++; $display("[TB] FAIL tx_hold_wren: got %0b expected 0", serial_wren_out); end
      if (stall) stalled++;
      @(negedge clock);
      #1;
      if (stall) stalled++;
      checks++; if (stalled !== 2) begin errors++; $display("[TB] FAIL tx_b2b_stall_cycles: got %0d expected 2", stalled); end
      checks++; if (serial_out !== 8'hC3) begin errors++; $display("[TB] FAIL tx_out_kept: got %h expected c3", serial_out); end
      @(negedge clock);
      mem_wr = 1'b0;
      #1;
      checks++; if (serial_out !== 8'hA5) begin errors++; $display("[TB] FAIL tx_second_out: got %h expected a5", serial_out); end
      checks++; if (serial_wren_out !== 1'b1) begin errors++; $display("[TB] FAIL tx_second_wren: got %0b expected 1", serial_wren_out); end
      bus_idle();
      repeat (3) @(negedge clock);
   endtask

   task automatic test_tx_not_ready();
      int stalled = 0;
      int pulses  = 0;
      @(negedge clock);
      mem_wr = 1'b1; mem_addr = DATA_A; mem_wdata = 32'h0000_007E; serial_ready_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (stall) stalled++;
         if (serial_wren_out) pulses++;
         @(negedge clock);
      end
      checks++; if (stalled !== 10) begin errors++; $display("[TB] FAIL tx_nr_stall_cycles: got %0d expected 10", stalled); end
      checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL tx_nr_no_wren: got %0d expected 0", pulses); end
      serial_ready_in = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL tx_nr_release: got %0b expected 0", stall); end
      @(negedge clock);
      mem_wr = 1'b0;
      #1;
      checks++; if (serial_out !== 8'h7E) begin errors++; $display("[TB] FAIL tx_nr_out: got %h expected 7e", serial_out); end
      repeat (2) @(negedge clock);
      mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = DATA_A; mem_wdata = 32'h0000_0099;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rdwr_stall: got %0b expected 0", stall); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rdwr_rdata: got %h expected 00000000", mem_rdata); end
      @(negedge clock);
      mem_rd = 1'b0; mem_wr = 1'b0;
      #1;
      checks++; if (serial_wren_out !== 1'b1) begin errors++; $display("[TB] FAIL rdwr_wren: got %0b expected 1", serial_wren_out); end
      checks++; if (serial_out !== 8'h99) begin errors++; $display("[TB] FAIL rdwr_out: got %h expected 99", serial_out); end
      repeat (2) @(negedge clock);
      mem_rd = 1'b1; mem_addr = 32'h0000_1000;
      #1;
      checks++; if (mem_hit !== 1'b0) begin errors++; $display("[TB] FAIL miss_hit: got %0b expected 0", mem_hit); end
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL miss_stall: got %0b expected 0", stall); end
      bus_idle();
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b0;
      bus_idle();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      test_reset();
      test_rx_single();
      test_rx_stall();
      test_rx_full();
      test_back_to_back();
      test_tx_not_ready();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
